// File: rtl/ufp_div_seq.sv
// Sequential unsigned fixed-point divider (restoring, one quotient bit per clock).
// Define UFP_DIV_ROUND_EN to add a guard quotient bit with round-half-up.
module ufp_div_seq #(
  parameter int IW   = 8,
  parameter int QW   = 8,
  parameter int CLIP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW+QW-1:0]     x_val,
  input  logic [IW+QW-1:0]     y_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW+QW-1:0]     out_val,
  output logic                 clipping,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int W = IW + QW;
`ifdef UFP_DIV_ROUND_EN
  localparam int ITER = W + QW + 1;
`else
  localparam int ITER = W + QW;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [ITER-1:0] n_q;
  logic [W-1:0]    d_q;
  logic [W:0]      r_q;
  logic [ITER-1:0] q_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    out_val_q;
  logic            clipping_q;
  logic            div_by_zero_q;
  logic            busy_q;

  logic [W:0]      r_shift_s;
  logic            r_ge_s;
  logic [W:0]      r_d;
  logic [ITER-1:0] q_d;
  logic            ovf_s;
  logic [W-1:0]    res_s;
  logic [W-1:0]    result_s;
  logic            r_unused_s;

  // The remainder stays below D after every step, so its top bit is never read.
  assign r_unused_s = r_q[W];

  // One restoring-division step: shift in the next dividend bit, trial-subtract D.
  always_comb begin
    r_shift_s = {r_q[W-1:0], n_q[ITER-1]};
    r_ge_s    = (r_shift_s >= {1'b0, d_q});
    if (r_ge_s) begin
      r_d = r_shift_s - {1'b0, d_q};
    end else begin
      r_d = r_shift_s;
    end
    q_d = {q_q[ITER-2:0], r_ge_s};
  end

`ifdef UFP_DIV_ROUND_EN
  logic [ITER-1:0] q_rnd_s;
  // Guard bit rounds half up; a carry out of the low W bits is overflow.
  assign q_rnd_s = {1'b0, q_q[ITER-1:1]} + {{(ITER-1){1'b0}}, q_q[0]};
  assign ovf_s   = |q_rnd_s[ITER-1:W];
  assign res_s   = q_rnd_s[W-1:0];
`else
  assign ovf_s = |q_q[ITER-1:W];
  assign res_s = q_q[W-1:0];
`endif

  // Overflow policy: saturate when CLIP is set, otherwise keep the low W bits.
  always_comb begin
    if ((CLIP != 0) && ovf_s) begin
      result_s = {W{1'b1}};
    end else begin
      result_s = res_s;
    end
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      d_q           <= '0;
      r_q           <= '0;
      q_q           <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_val_q     <= '0;
      clipping_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            n_q        <= {x_val, {(ITER-W){1'b0}}};
            d_q        <= y_val;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= ITER_C;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (y_val == {W{1'b0}}) begin
              state_q       <= S_DONE;
              out_valid_q   <= 1'b1;
              out_val_q     <= {W{1'b1}};
              clipping_q    <= 1'b1;
              div_by_zero_q <= 1'b1;
            end else begin
              state_q       <= S_CALC;
              clipping_q    <= 1'b0;
              div_by_zero_q <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (cnt_q != {CW{1'b0}}) begin
            r_q   <= r_d;
            q_q   <= q_d;
            n_q   <= {n_q[ITER-2:0], 1'b0};
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end else begin
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_val_q     <= result_s;
            clipping_q    <= ovf_s;
            div_by_zero_q <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_val     = out_val_q;
  assign clipping    = clipping_q;
  assign div_by_zero = div_by_zero_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ufp_div_seq.sv
// Directed self-checking bench for ufp_div_seq: a wrapping (CLIP=0) and a
// saturating (CLIP=1) instance share one stimulus stream.
module tb_ufp_div_seq;

`ifdef UFP_DIV_ROUND_EN
  localparam int          LAT_EXP  = 26;
  localparam logic [15:0] FRAC_EXP = 16'h00AB;
`else
  localparam int          LAT_EXP  = 25;
  localparam logic [15:0] FRAC_EXP = 16'h00AA;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x_val = 16'h0000;
  logic [15:0] y_val = 16'h0000;

  logic        rdy0, vld0, clip0, dbz0, busy0;
  logic        rdy1, vld1, clip1, dbz1, busy1;
  logic [15:0] val0, val1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ufp_div_seq #(.IW(8), .QW(8), .CLIP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .x_val(x_val), .y_val(y_val), .out_valid(vld0), .out_ready(out_ready),
    .out_val(val0), .clipping(clip0), .div_by_zero(dbz0), .busy(busy0)
  );

  ufp_div_seq #(.IW(8), .QW(8), .CLIP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .x_val(x_val), .y_val(y_val), .out_valid(vld1), .out_ready(out_ready),
    .out_val(val1), .clipping(clip1), .div_by_zero(dbz1), .busy(busy1)
  );

  // Present operands, wait for in_ready (bounded), then scramble inputs after acceptance.
  task automatic accept(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", rdy0);
    end
    x_val    = x;
    y_val    = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_val    = 16'hFFFF;
    y_val    = 16'h0001;
  endtask

  // Count edges after acceptance until out_valid; -1 if it never rises.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (vld0 === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, vld0, val0, clip0, dbz0, busy0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b val=%h clip=%b dbz=%b busy=%b required all 0",
               rdy0, vld0, val0, clip0, dbz0, busy0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: in_ready=%b required 0", rdy0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: in_ready=%b/%b required 1", rdy0, rdy1);
    end
  endtask

  task automatic test_basic();
    int lat;
    accept(16'h0300, 16'h0180);
    checks++;
    if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b in_ready=%b required 1/0", busy0, rdy0);
    end
    wait_result(lat);
    checks++;
    if (lat !== LAT_EXP) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, LAT_EXP);
    end
    checks++;
    if (val0 !== 16'h0200 || clip0 !== 1'b0 || dbz0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %h clip=%b dbz=%b required 0200 0 0", val0, clip0, dbz0);
    end
    consume();
  endtask

  task automatic test_fraction();
    int lat;
    accept(16'h0200, 16'h0300);
    wait_result(lat);
    checks++;
    if (lat !== LAT_EXP || val0 !== FRAC_EXP || clip0 !== 1'b0) begin
      errors++;
      $display("FAIL fraction: got %h clip=%b lat=%0d required %h 0 %0d", val0, clip0, lat, FRAC_EXP, LAT_EXP);
    end
    consume();
    accept(16'h0000, 16'h0123);
    wait_result(lat);
    checks++;
    if (val0 !== 16'h0000 || clip0 !== 1'b0 || val1 !== 16'h0000) begin
      errors++;
      $display("FAIL zero_dividend: got %h/%h clip=%b required 0000 0", val0, val1, clip0);
    end
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    accept(16'h6400, 16'h0040);
    wait_result(lat);
    checks++;
    if (val0 !== 16'h9000 || clip0 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wrap: got %h clip=%b required 9000 1", val0, clip0);
    end
    checks++;
    if (vld1 !== 1'b1 || val1 !== 16'hFFFF || clip1 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sat: got vld=%b %h clip=%b required 1 FFFF 1", vld1, val1, clip1);
    end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat;
    accept(16'h1234, 16'h0000);
    wait_result(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got %0d required 1", lat);
    end
    checks++;
    if (val0 !== 16'hFFFF || dbz0 !== 1'b1 || clip0 !== 1'b1 ||
        val1 !== 16'hFFFF || dbz1 !== 1'b1 || clip1 !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got %h dbz=%b clip=%b / %h dbz=%b clip=%b required FFFF 1 1",
               val0, dbz0, clip0, val1, dbz1, clip1);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    accept(16'h0300, 16'h0180);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (vld0 !== 1'b1 || val0 !== 16'h0200 || rdy0 !== 1'b0 || busy0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles required 0 (vld=%b val=%h rdy=%b)",
               bad, vld0, val0, rdy0);
    end
    consume();
    checks++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b busy=%b required 0 1 0", vld0, rdy0, busy0);
    end
    accept(16'h0100, 16'h0100);
    wait_result(lat);
    checks++;
    if (lat !== LAT_EXP || val0 !== 16'h0100) begin
      errors++;
      $display("FAIL back_to_back: got %h lat=%0d required 0100 %0d", val0, lat, LAT_EXP);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    accept(16'h0300, 16'h0180);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, vld0, val0, clip0, dbz0, busy0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%b vld=%b val=%h busy=%b required all 0",
               rdy0, vld0, val0, busy0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (vld0 !== 1'b0 || vld1 !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result: out_valid seen %0d cycles required 0", seen);
    end
    accept(16'h0800, 16'h0200);
    wait_result(lat);
    checks++;
    if (lat !== LAT_EXP || val0 !== 16'h0400 || clip0 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got %h lat=%0d required 0400 %0d", val0, lat, LAT_EXP);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
